// File: rtl/ll_rx_pkg.sv
// ll_rx_pkg: shared state encoding, counter-width helper and debug counter width for the link receive side.
package ll_rx_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, ACTIVE = 2'd2} rx_state_e;
  localparam int LL_DBG_CNT_W = 16;
  function automatic int clog2p1(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/ll_sat_cnt.sv
// ll_sat_cnt: saturating up-counter with synchronous clear.
module ll_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc & ~&cnt_q) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/ll_rx_ctrl_cred.sv
// ll_rx_ctrl_cred: credit-based link receive control; grants the initial credit pool, tracks FIFO occupancy, returns credits.
// Define LL_RX_CTRL_DBG_CNT_EN to add saturating write/credit-return debug counters.
module ll_rx_ctrl_cred
  import ll_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = clog2p1(FIFO_DEPTH)
) (
  input  logic             clk_wr,
  input  logic             rst_wr,
  input  logic             rx_online,
  input  logic             rxfifo_i_push,
  output logic             rxfifo_i_wr,
  output logic             rxfifo_i_pop,
  output logic             user_o_valid,
  input  logic             user_o_ready,
  output logic             rx_credit_ret,
  output logic [CNT_W-1:0] rx_occupancy,
  output logic             rx_overflow
`ifdef LL_RX_CTRL_DBG_CNT_EN
  ,
  output logic [LL_DBG_CNT_W-1:0] dbg_wr_cnt,
  output logic [LL_DBG_CNT_W-1:0] dbg_ret_cnt
`endif
);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_DEPTH);
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] occ_q, occ_d, pend_q, pend_d, grant_q, grant_d;
  logic             ovf_q, ovf_d, act_ret;
  always_comb begin
    user_o_valid  = (occ_q != '0) & rx_online & (state_q != IDLE);
    rxfifo_i_pop  = user_o_valid & user_o_ready;
    rxfifo_i_wr   = rxfifo_i_push & rx_online & ((occ_q < DEPTH) | rxfifo_i_pop);
    act_ret       = (state_q == ACTIVE) & (pend_q != '0);
    rx_credit_ret = rx_online & ((state_q == GRANT) | act_ret);
    state_d = !rx_online ? IDLE :
              (state_q == IDLE) ? GRANT :
              (state_q == GRANT && grant_q == CNT_W'(1)) ? ACTIVE : state_q;
    grant_d = (state_q == IDLE) ? DEPTH : (state_q == GRANT) ? grant_q - CNT_W'(1) : grant_q;
    occ_d   = !rx_online ? '0 : occ_q + CNT_W'(rxfifo_i_wr) - CNT_W'(rxfifo_i_pop);
    // pops made while granting are banked here and returned once ACTIVE
    pend_d  = (!rx_online || state_q == IDLE) ? '0 :
              pend_q + CNT_W'(rxfifo_i_pop) - CNT_W'(act_ret);
    ovf_d   = rx_online & (ovf_q | (rxfifo_i_push & ~rxfifo_i_wr));
  end
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state_q <= IDLE;
      occ_q   <= '0;
      pend_q  <= '0;
      grant_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      pend_q  <= pend_d;
      grant_q <= grant_d;
      ovf_q   <= ovf_d;
    end
  end
  assign rx_occupancy = occ_q;
  assign rx_overflow  = ovf_q;
`ifdef LL_RX_CTRL_DBG_CNT_EN
  ll_sat_cnt #(.W(LL_DBG_CNT_W)) u_wr_cnt (
    .clk(clk_wr), .rst(rst_wr), .clr(1'b0), .inc(rxfifo_i_wr), .cnt(dbg_wr_cnt)
  );
  ll_sat_cnt #(.W(LL_DBG_CNT_W)) u_ret_cnt (
    .clk(clk_wr), .rst(rst_wr), .clr(1'b0), .inc(rx_credit_ret), .cnt(dbg_ret_cnt)
  );
`endif
endmodule

// File: tb/tb_ll_rx_ctrl_cred.sv
// tb_ll_rx_ctrl_cred: randomized and directed bench for ll_rx_ctrl_cred against a link-age based reference model.
module tb_ll_rx_ctrl_cred;
  localparam int D  = 8;
  localparam int CW = 4;
  logic clk_wr = 0, rst_wr = 1, rx_online = 0, rxfifo_i_push = 0, user_o_ready = 0;
  logic rxfifo_i_wr, rxfifo_i_pop, user_o_valid, rx_credit_ret, rx_overflow;
  logic [CW-1:0] rx_occupancy;
`ifdef LL_RX_CTRL_DBG_CNT_EN
  logic [15:0] dbg_wr_cnt, dbg_ret_cnt;
`endif
  int tests = 0, fails = 0;
  int m_age, m_occ, m_pend, m_far;
  logic m_ovf;
  logic s_ret, s_pop, s_wr, s_valid;

  ll_rx_ctrl_cred #(.FIFO_DEPTH(D)) dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr), .rx_online(rx_online), .rxfifo_i_push(rxfifo_i_push),
    .rxfifo_i_wr(rxfifo_i_wr), .rxfifo_i_pop(rxfifo_i_pop), .user_o_valid(user_o_valid),
    .user_o_ready(user_o_ready), .rx_credit_ret(rx_credit_ret), .rx_occupancy(rx_occupancy),
    .rx_overflow(rx_overflow)
`ifdef LL_RX_CTRL_DBG_CNT_EN
    , .dbg_wr_cnt(dbg_wr_cnt), .dbg_ret_cnt(dbg_ret_cnt)
`endif
  );

  always #5 clk_wr = ~clk_wr;

  // m_age counts consecutive cycles the link has been online before the current one:
  // 0 = idle, 1..D = granting, >D = active.
  task automatic step(input logic on, input logic pu, input logic rd);
    logic e_valid, e_pop, e_wr, e_ret;
    rx_online = on; rxfifo_i_push = pu; user_o_ready = rd;
    #1;
    e_valid = on && m_age > 0 && m_occ > 0;
    e_pop   = e_valid && rd;
    e_wr    = pu && on && (m_occ < D || e_pop);
    e_ret   = on && ((m_age >= 1 && m_age <= D) || (m_age > D && m_pend > 0));
    tests++;
    if ({user_o_valid, rxfifo_i_pop, rxfifo_i_wr, rx_credit_ret} !== {e_valid, e_pop, e_wr, e_ret}) begin
      fails++;
      $display("FAIL step_comb valid/pop/wr/ret got %b%b%b%b want %b%b%b%b", user_o_valid, rxfifo_i_pop,
               rxfifo_i_wr, rx_credit_ret, e_valid, e_pop, e_wr, e_ret);
    end
    s_ret = rx_credit_ret; s_pop = rxfifo_i_pop; s_wr = rxfifo_i_wr; s_valid = user_o_valid;
    @(posedge clk_wr); #1;
    if (!on) begin
      m_age = 0; m_occ = 0; m_pend = 0; m_far = 0; m_ovf = 0;
    end else begin
      m_occ = m_occ + int'(e_wr) - int'(e_pop);
      if (pu && !e_wr) m_ovf = 1;
      if (m_age >= 1) m_pend = m_pend + int'(e_pop) - int'(m_age > D && m_pend > 0);
      m_far = m_far + int'(e_ret) - int'(e_wr);
      if (m_age < 1000) m_age++;
    end
    tests++;
    if (rx_occupancy !== CW'(m_occ) || rx_overflow !== m_ovf) begin
      fails++;
      $display("FAIL step_state occ=%0d ovf=%b want occ=%0d ovf=%b", rx_occupancy, rx_overflow, m_occ, m_ovf);
    end
  endtask

  task automatic test_reset();
    rst_wr = 1; rx_online = 0; rxfifo_i_push = 0; user_o_ready = 0;
    repeat (3) @(posedge clk_wr);
    #1;
    tests++;
    if ({rx_credit_ret, rx_overflow, user_o_valid, rxfifo_i_pop, rxfifo_i_wr} !== 5'b0 || rx_occupancy !== '0) begin
      fails++;
      $display("FAIL reset outputs ret/ovf/valid/pop/wr=%b%b%b%b%b occ=%0d want all 0", rx_credit_ret,
               rx_overflow, user_o_valid, rxfifo_i_pop, rxfifo_i_wr, rx_occupancy);
    end
    rst_wr = 0;
    m_age = 0; m_occ = 0; m_pend = 0; m_far = 0; m_ovf = 0;
  endtask

  task automatic bring_up(output int pulses);
    pulses = 0;
    step(1, 0, 0);
    for (int i = 0; i < D; i++) begin
      step(1, 0, 0);
      pulses += int'(s_ret);
    end
  endtask

  task automatic test_bringup();
    int p;
    step(0, 0, 0); step(0, 0, 0);
    bring_up(p);
    tests++;
    if (p != D) begin fails++; $display("FAIL bringup_pulses got %0d want %0d", p, D); end
    step(1, 0, 0);
    tests++;
    if (s_ret !== 1'b0 || s_valid !== 1'b0) begin
      fails++; $display("FAIL bringup_active ret=%b valid=%b want 0 0", s_ret, s_valid);
    end
  endtask

  task automatic test_fill_drain();
    int pops;
    pops = 0;
    repeat (D) step(1, 1, 0);
    tests++;
    if (rx_occupancy !== CW'(D)) begin fails++; $display("FAIL fill_occ got %0d want %0d", rx_occupancy, D); end
    for (int i = 0; i < D + 2; i++) begin
      step(1, 0, i < D);
      pops += int'(s_pop);
      tests++;
      if (s_ret !== (i >= 1 && i <= D)) begin
        fails++; $display("FAIL drain_ret cycle %0d got %b want %b", i, s_ret, (i >= 1 && i <= D));
      end
    end
    tests++;
    if (pops != D || rx_occupancy !== '0) begin
      fails++; $display("FAIL drain_pops pops=%0d occ=%0d want %0d 0", pops, rx_occupancy, D);
    end
  endtask

  task automatic test_full_pushpop();
    repeat (D) step(1, 1, 0);
    step(1, 1, 1);
    tests++;
    if (s_wr !== 1'b1 || rx_occupancy !== CW'(D) || rx_overflow !== 1'b0) begin
      fails++; $display("FAIL full_pushpop wr=%b occ=%0d ovf=%b want 1 %0d 0", s_wr, rx_occupancy, rx_overflow, D);
    end
  endtask

  task automatic test_overflow();
    step(1, 1, 0);
    tests++;
    if (s_wr !== 1'b0 || rx_overflow !== 1'b1) begin
      fails++; $display("FAIL overflow_set wr=%b ovf=%b want 0 1", s_wr, rx_overflow);
    end
    repeat (3) step(1, 0, 0);
    tests++;
    if (rx_overflow !== 1'b1) begin fails++; $display("FAIL overflow_sticky got %b want 1", rx_overflow); end
    step(0, 0, 0);
    tests++;
    if (rx_overflow !== 1'b0 || rx_occupancy !== '0) begin
      fails++; $display("FAIL overflow_clear ovf=%b occ=%0d want 0 0", rx_overflow, rx_occupancy);
    end
  endtask

  task automatic test_offline();
    int rets, p;
    rets = 0;
    step(1, 0, 0);
    repeat (5) step(1, 1, 0);
    repeat (2) step(1, 0, 1);
    tests++;
    if (rx_occupancy !== CW'(3)) begin fails++; $display("FAIL offline_pre_occ got %0d want 3", rx_occupancy); end
    step(1, 0, 0);
    step(0, 0, 0);
    repeat (4) begin
      step(0, 0, 0);
      rets += int'(s_ret);
    end
    tests++;
    if (rets != 0 || rx_occupancy !== '0) begin
      fails++; $display("FAIL offline_quiet rets=%0d occ=%0d want 0 0", rets, rx_occupancy);
    end
    bring_up(p);
    tests++;
    if (p != D) begin fails++; $display("FAIL regrant_pulses got %0d want %0d", p, D); end
  endtask

  task automatic test_random();
    logic on, pu;
    for (int i = 0; i < 400; i++) begin
      on = ($urandom_range(0, 63) != 0);
      pu = on && m_far > 0 && ($urandom_range(0, 1) == 1);
      step(on, pu, $urandom_range(0, 2) != 0);
      if (m_age > D) begin
        tests++;
        if (int'(rx_occupancy) + m_pend + m_far != D) begin
          fails++; $display("FAIL credit_invariant occ=%0d pend=%0d far=%0d want sum %0d", rx_occupancy, m_pend, m_far, D);
        end
      end
    end
  endtask

`ifdef LL_RX_CTRL_DBG_CNT_EN
  task automatic test_dbg();
    int p;
    test_reset();
    step(0, 0, 0);
    bring_up(p);
    repeat (5) begin step(1, 1, 0); step(1, 0, 1); end
    repeat (3) step(1, 0, 0);
    tests++;
    if (dbg_wr_cnt !== 16'd5 || dbg_ret_cnt !== 16'd13) begin
      fails++; $display("FAIL dbg_cnt wr=%0d ret=%0d want 5 13", dbg_wr_cnt, dbg_ret_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bringup();
    test_fill_drain();
    test_full_pushpop();
    test_overflow();
    test_offline();
    test_random();
`ifdef LL_RX_CTRL_DBG_CNT_EN
    test_dbg();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
